// File: rtl/issue_hazard_ctrl_pkg.sv
// Shared decode definitions for the issue controller: field positions, NOP and the instruction decoder.
// Pure combinational helpers; no latency or backpressure of their own.
package issue_hazard_ctrl_pkg;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;

    localparam logic [31:0] NOP = 32'h0;

    typedef struct packed {
        logic       we;
        logic [4:0] dest;
    } slotT;

    typedef struct packed {
        logic readsRs;
        logic readsRt;
        slotT wr;
    } decodeT;

    // Register 0 is an ordinary register here; only the all-zero word is a NOP.
    function automatic decodeT decodeInstr(input logic [31:0] instr);
        decodeT d;
        d = '0;
        if (instr != NOP) begin
            d.readsRs = 1'b1;
            d.wr.we   = 1'b1;
            if (instr[OP_MSB:OP_LSB] == '0) begin
                d.readsRt = 1'b1;
                d.wr.dest = instr[RD_MSB:RD_LSB];
            end else begin
                d.wr.dest = instr[RT_MSB:RT_LSB];
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/issue_hazard_ctrl_hazard_scoreboard.sv
// In-flight destination tracker: one slot per pipeline cycle until writeback, raises RAW hazard for a candidate.
// Hazard/WbWe/Busy are combinational from the slots; slots shift every cycle, cleared by Flush.
module hazard_scoreboard
    import issue_hazard_ctrl_pkg::*;
#(
    parameter int WB_LAT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Flush,
    input  logic       Issue,
    input  slotT       NewSlot,
    input  logic       ReadsRs,
    input  logic       ReadsRt,
    input  logic [4:0] SrcRs,
    input  logic [4:0] SrcRt,
    output logic       Hazard,
    output logic       WbWe,
    output logic       Busy
);

    slotT slot [WB_LAT];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < WB_LAT; i++) slot[i] <= '0;
        end else if (Flush) begin
            for (int i = 0; i < WB_LAT; i++) slot[i] <= '0;
        end else begin
            slot[0] <= Issue ? NewSlot : '0;
            for (int i = 1; i < WB_LAT; i++) slot[i] <= slot[i-1];
        end
    end

    // The writeback slot is skipped: it commits before the candidate reads the register file.
    always_comb begin
        Hazard = 1'b0;
        Busy   = 1'b0;
        for (int i = 0; i < WB_LAT; i++) begin
            Busy = Busy | slot[i].we;
            if ((i < WB_LAT - 1) && slot[i].we &&
                ((ReadsRs && (slot[i].dest == SrcRs)) || (ReadsRt && (slot[i].dest == SrcRt)))) begin
                Hazard = 1'b1;
            end
        end
    end

    assign WbWe = slot[WB_LAT-1].we;

endmodule

// File: rtl/issue_hazard_ctrl.sv
// Issue controller for a no-forwarding 3-stage pipeline: inserts NOP bubbles on RAW hazards and counts issue/stall cycles.
// Accepted instruction appears on InstrIn next cycle; InReady drops on hazard or Flush, independent of InValid.
module issue_hazard_ctrl
    import issue_hazard_ctrl_pkg::*;
#(
    parameter int WB_LAT = 2,
    parameter int CNT_W  = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Flush,
    input  logic             InValid,
    input  logic [31:0]      InInstr,
    output logic             InReady,
    output logic [31:0]      InstrIn,
    output logic             WriteEnable,
    output logic             Busy,
    output logic [CNT_W-1:0] IssueCount,
    output logic [CNT_W-1:0] StallCount
);

    decodeT cand;
    logic   hazard;
    logic   issue;

    assign cand    = decodeInstr(InInstr);
    assign InReady = !hazard && !Flush;
    assign issue   = InValid && InReady;

    hazard_scoreboard #(
        .WB_LAT (WB_LAT)
    ) uScoreboard (
        .Clk     (Clk),
        .Reset   (Reset),
        .Flush   (Flush),
        .Issue   (issue),
        .NewSlot (cand.wr),
        .ReadsRs (cand.readsRs),
        .ReadsRt (cand.readsRt),
        .SrcRs   (InInstr[RS_MSB:RS_LSB]),
        .SrcRt   (InInstr[RT_MSB:RT_LSB]),
        .Hazard  (hazard),
        .WbWe    (WriteEnable),
        .Busy    (Busy)
    );

    // Flush needs no extra term: it already forces issue low, which loads a NOP.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            InstrIn    <= NOP;
            IssueCount <= '0;
            StallCount <= '0;
        end else begin
            InstrIn <= issue ? InInstr : NOP;
            if (issue) IssueCount <= IssueCount + CNT_W'(1);
            if (InValid && hazard && !Flush) StallCount <= StallCount + CNT_W'(1);
        end
    end

endmodule

// File: doc/issue_hazard_ctrl.md
Name: issue_hazard_ctrl

Overview:
- Issue controller placed in front of the 3-stage fetch/decode/execute pipeline. It accepts instructions over a valid/ready handshake and drives the pipeline's InstrIn and WriteEnable.
- The pipeline has no forwarding, so the controller detects read-after-write hazards against in-flight destinations and inserts NOP bubbles until each result is written back.
- It also counts issued and stalled cycles.

Parameters:
- WB_LAT, 2, cycles from an instruction appearing on InstrIn to the end of its writeback cycle (its S3 cycle); legal range 2..4.
- CNT_W, 16, width of IssueCount and StallCount.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Flush  input  1  synchronous kill of the in-flight tracker and issue slot.
- InValid  input  1  source offers InInstr.
- InInstr  input  32  offered instruction.
- InReady  output  1  controller accepts InInstr this cycle.
- InstrIn  output  32  registered instruction to the pipeline decode stage; NOP = 32'h0.
- WriteEnable  output  1  register-file write enable for the instruction currently in the writeback stage.
- Busy  output  1  any tracker slot holds a pending write.
- IssueCount  output  CNT_W  number of accepted instructions, wraps.
- StallCount  output  CNT_W  cycles with InValid=1 and a hazard, wraps.

Behaviour:
- Decode, using the fields [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd:
  - InInstr==0: NOP; no reads, no write.
  - op==0: R-type; reads rs and rt; writes rd.
  - op!=0: I-type; reads rs only; writes rt.
  - Register 0 is treated like any other register: no special case.
- Tracker: shift register slot[0..WB_LAT-1], each slot holding {we, dest[4:0]}.
  - slot[0] belongs to the instruction currently on InstrIn.
  - slot[WB_LAT-1] belongs to the instruction in writeback.
- WriteEnable = slot[WB_LAT-1].we, combinational from the register.
- Hazard: asserted when any of slot[0..WB_LAT-2] has we=1 and a dest equal to a source the candidate actually reads.
  - slot[WB_LAT-1] is excluded, because its write commits at the end of the current cycle, before the candidate reads.
- InReady = !hazard && !Flush. This is combinational, and InReady does not depend on InValid.
- Issue = InValid && InReady. On each rising edge:
  - InstrIn <= issue ? InInstr : 0.
  - slot[0] <= issue ? decoded {we, dest} : 0.
  - slot[i] <= slot[i-1].
- Latency: an accepted instruction appears on InstrIn the next cycle. Dependent back-to-back instructions cost WB_LAT-1 bubble cycles.
- Counters:
  - IssueCount increments on issue.
  - StallCount increments when InValid && hazard && !Flush.
  - Both wrap modulo 2^CNT_W and are never cleared by Flush.
- Flush:
  - In the Flush cycle, InReady=0 and nothing is issued.
  - The write already in the writeback stage still commits, because WriteEnable keeps its current value during that cycle.
  - At the edge, InstrIn <= 0 and all slots are cleared, so WriteEnable=0 from the next cycle.
- Reset (asynchronous, active-low): InstrIn=0, all slots=0, WriteEnable=0, Busy=0, IssueCount=0, StallCount=0.
  - InReady comes up 1 once reset is released.
  - Reset mid-operation discards in-flight writes immediately.
- Simultaneous Flush and a hazard: Flush dominates; StallCount does not increment.
- Busy = OR of slot[*].we.

Decomposition:
- Shared package holds:
  - field positions (OP_MSB/LSB, RS, RT, RD);
  - NOP constant 32'h0;
  - the decode function returning {reads_rs, reads_rt, we, dest}.
- One natural sub-module, hazard_scoreboard:
  - holds the WB_LAT slots and the shift logic;
  - takes the candidate sources as inputs and returns the hazard flag and the writeback we.

Test Plan:
- Reset low with InValid=1 -> InstrIn=0, WriteEnable=0, counters 0. Reset high -> InReady=1.
- Independent pair, WB_LAT=2: 32'h00221800 (R rd=3) then 32'h04A60007 (I rs=5) on consecutive cycles -> both accepted; InstrIn shows them in consecutive cycles; StallCount=0; IssueCount=2.
- RAW dependency, WB_LAT=2: 32'h00221800 then 32'h04640005 (I rs=3) -> one InReady=0 cycle; one NOP on InstrIn; WriteEnable=1 in the cycle after the first instruction leaves InstrIn; StallCount=1.
- NOP source: 32'h0 followed by 32'h00000800 (R rs=0, rt=0) -> no stall, because a NOP records we=0.
- Flush while a dependent instruction is stalled:
  - Flush cycle -> InReady=0, StallCount unchanged.
  - Next cycle -> WriteEnable=0, Busy=0, and the stalled instruction issues without a bubble.
- WB_LAT=3, dependency 32'h00221800 then 32'h04640005 -> exactly 2 bubble cycles, StallCount=2.
